// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with internal oversampling tick and mid-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err output.
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | timing to mid start bit, rejecting glitches
// DATA      | sampling 8 data bits, LSB first
// PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP      | sampling the stop bit, loading or flagging the byte
// WAIT_IDLE | framing error seen, waiting for the line to go high
module uart_rx_oversample #(
    parameter int BAUDRATE   = 115200,
    parameter int CLK_HZ     = 100_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       busy,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun
);

    localparam int DIV = CLK_HZ / (BAUDRATE * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t          state;
    logic [1:0]      sync;
    logic            rx_s;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [TW-1:0]   tcnt;
    logic [2:0]      bitcnt;
    logic [7:0]      shift;
    logic            mid_start;
    logic            mid_bit;
`ifdef UART_RX_PARITY_EN
    logic            par_bit;
    logic            par_bad;
`endif

    // Synchronizer resets to the idle line level so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx_in};
        end
    end

    assign rx_s = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (state == IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tick      = (div_cnt == DIV_LAST);
    assign mid_start = tick && (tcnt == HALF_LAST);
    assign mid_bit   = tick && (tcnt == FULL_LAST);

`ifdef UART_RX_PARITY_EN
    assign par_bad = (par_bit != ^shift);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tcnt       <= '0;
            bitcnt     <= '0;
            shift      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (tick) begin
                tcnt <= ((state == START) ? mid_start : mid_bit) ? '0 : tcnt + TW'(1);
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                        tcnt  <= '0;
                    end
                end
                START: begin
                    if (mid_start) begin
                        bitcnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (mid_bit) begin
                        shift <= {rx_s, shift[7:1]};
                        if (bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bitcnt <= bitcnt + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid_bit) begin
                        par_bit <= rx_s;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (mid_bit) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else
`endif
                            // An accept in this same cycle frees the register, so the new byte wins.
                            if (data_valid && !data_ready) begin
                                overrun <= 1'b1;
                            end else begin
                                data       <= shift;
                                data_valid <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: directed frames, expected events queued, monitor compares.
module tb_uart_rx_oversample;

    localparam int BAUD   = 115200;
    localparam int CLK_F  = 7_372_800;
    localparam int OS     = 16;
    localparam int DIV    = CLK_F / (BAUD * OS);
    localparam int BIT    = OS * DIV;

    localparam int EV_DATA  = 0;
    localparam int EV_FRAME = 1;
    localparam int EV_OVR   = 2;
    localparam int EV_PAR   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       data_ready = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    typedef struct {
        int         kind;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic dv_q = 1'b0;

    uart_rx_oversample #(
        .BAUDRATE(BAUD),
        .CLK_HZ(CLK_F),
        .OVERSAMPLE(OS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_in(rx_in),
        .data(data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .busy(busy),
        .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(int kind, logic [7:0] v);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic got(int kind, logic [7:0] v);
        exp_t e;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d value %02h, expected none", kind, v);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.val !== v) begin
                miscompares++;
                $display("FAIL event: got kind %0d value %02h, expected kind %0d value %02h",
                         kind, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: every output event is matched against the scoreboard in arrival order.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid && !dv_q) got(EV_DATA, data);
            if (frame_err) got(EV_FRAME, 8'h00);
`ifdef UART_RX_PARITY_EN
            if (parity_err) got(EV_PAR, 8'h00);
`endif
            if (overrun) got(EV_OVR, 8'h00);
        end
        dv_q = data_valid;
    end

    task automatic drive_bit(logic b);
        rx_in = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_head(logic [7:0] b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
    endtask

    task automatic send_frame(logic [7:0] b, logic stop_bit);
        send_head(b);
        drive_bit(stop_bit);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(logic [7:0] b, logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        drive_bit(1'b1);
    endtask
`endif

    task automatic wait_valid(string name, int limit);
        int n = 0;
        while (!data_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(data_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_data"}, 32'(data), 32'h00);
        check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
`ifdef UART_RX_PARITY_EN
        check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
`endif
    endtask

    initial begin
        @(negedge clk);
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;

        // 0x55 with consumer ready: one-cycle data_valid, busy low afterwards
        expect_ev(EV_DATA, 8'h55);
        send_head(8'h55);
        rx_in = 1'b1;
        wait_valid("x55_valid", 2 * BIT);
        @(negedge clk);
        check("x55_valid_width", 32'(data_valid), 32'd0);
        @(posedge clk);
        #1;
        repeat (BIT) @(posedge clk);
        #1;
        check("x55_busy_after", 32'(busy), 32'd0);

        // Glitch of 3*DIV clocks is rejected as a false start
        rx_in = 1'b0;
        repeat (3 * DIV) @(posedge clk);
        #1;
        check("glitch_busy_during", 32'(busy), 32'd1);
        rx_in = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        #1;
        check("glitch_busy_after", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(data_valid), 32'd0);

        // 0xA3 with a low stop bit followed by a 2-bit break
        expect_ev(EV_FRAME, 8'h00);
        send_head(8'hA3);
        drive_bit(1'b0);
        repeat (2 * BIT) @(posedge clk);
        #1;
        check("break_busy_held", 32'(busy), 32'd1);
        check("break_no_valid", 32'(data_valid), 32'd0);
        rx_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("break_busy_released", 32'(busy), 32'd0);
        repeat (BIT) @(posedge clk);
        #1;

        // Back-to-back 0x11, 0x22 with no consumer: 0x11 held, overrun on 0x22
        data_ready = 1'b0;
        expect_ev(EV_DATA, 8'h11);
        expect_ev(EV_OVR, 8'h00);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        @(negedge clk);
        check("ovr_data_held", 32'(data), 32'h11);
        check("ovr_valid_held", 32'(data_valid), 32'd1);
        @(posedge clk);
        #1 data_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovr_accept_clears", 32'(data_valid), 32'd0);
        @(posedge clk);
        #1;
        repeat (BIT) @(posedge clk);
        #1;

        // Reset in the middle of 0xFF, then a clean 0x3C
        drive_bit(1'b0);
        repeat (3) drive_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        expect_ev(EV_DATA, 8'h3C);
        send_frame(8'h3C, 1'b1);
        repeat (BIT) @(posedge clk);
        #1;
        check("x3c_busy_after", 32'(busy), 32'd0);
        check("x3c_data", 32'(data), 32'h3C);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so even parity needs a 1
        expect_ev(EV_PAR, 8'h00);
        send_frame_par(8'h07, 1'b0);
        expect_ev(EV_DATA, 8'h07);
        send_frame_par(8'h07, 1'b1);
        repeat (BIT) @(posedge clk);
        #1;
        check("par_busy_after", 32'(busy), 32'd0);
`endif

        repeat (BIT) @(posedge clk);
        #1;
        check("pending_events", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
